// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor control path:
// FSM states, opcodes and instruction-register field positions.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_BZ  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1111;

    // IR layout: [15:12] opcode, [11:9] reg A / dest, [8:6] reg B,
    // [7:0] LDI immediate, [11:8] jump target (fields overlap by opcode).
    localparam int IR_OP_HI  = 15;
    localparam int IR_OP_LO  = 12;
    localparam int IR_RA_HI  = 11;
    localparam int IR_RA_LO  = 9;
    localparam int IR_RB_HI  = 8;
    localparam int IR_RB_LO  = 6;
    localparam int IR_IMM_HI = 7;
    localparam int IR_IMM_LO = 0;
    localparam int IR_TGT_HI = 11;
    localparam int IR_TGT_LO = 8;

    function automatic logic is_write_op(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides clk down to a one-clk step strobe every STEP_DIV clocks.
// Used by proc_sequencer only when STEP_PRESCALE_EN is defined.
module step_prescaler #(
    parameter int STEP_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic step
);

    localparam int            CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // With STEP_DIV=1 the counter sits at 0 and the strobe is always high.
    assign step = (cnt == LAST);

endmodule

// File: rtl/proc_sequencer.sv
// Four-state (FETCH/DECODE/EXEC/WB) control unit for the 16-bit processor.
// Define STEP_PRESCALE_EN to slow the FSM to one step every STEP_DIV clocks.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int ROM_SIZE = 16,
    parameter int STEP_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    input  logic [15:0] data_a,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic [3:0]  address,
    output logic [3:0]  opcode,
    output logic [2:0]  reg_a,
    output logic [2:0]  reg_b,
    output logic        write_enable,
    output logic [15:0] write_data,
    output logic        zero,
    output logic [15:0] result,
    output logic [1:0]  state
);

    localparam logic [3:0] PC_MASK = 4'(ROM_SIZE - 1);

    logic step;

`ifdef STEP_PRESCALE_EN
    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step)
    );
`else
    assign step = (STEP_DIV > 0);
`endif

    state_t      st, st_nxt;
    logic [15:0] ir;
    logic [3:0]  pc;
    logic        ir_load, exec_load, wb_exit;
    logic [3:0]  pc_inc, pc_tgt;

    assign opcode = ir[IR_OP_HI:IR_OP_LO];
    assign reg_a  = ir[IR_RA_HI:IR_RA_LO];
    assign reg_b  = ir[IR_RB_HI:IR_RB_LO];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= ST_FETCH;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (step) begin
            case (st)
                ST_FETCH:  st_nxt = ST_DECODE;
                ST_DECODE: st_nxt = ST_EXEC;
                ST_EXEC:   st_nxt = ST_WB;
                ST_WB:     st_nxt = ST_FETCH;
                default:   st_nxt = ST_FETCH;
            endcase
        end
    end

    // Capture strobes fire on the step that leaves the named state.
    always_comb begin
        ir_load   = 1'b0;
        exec_load = 1'b0;
        wb_exit   = 1'b0;
        if (step) begin
            ir_load   = (st == ST_DECODE);
            exec_load = (st == ST_EXEC);
            wb_exit   = (st == ST_WB);
        end
    end

    assign state = st;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir <= 16'h0000;
        else if (ir_load)
            ir <= instruction;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_data <= 16'h0000;
            zero       <= 1'b0;
            result     <= 16'h0000;
        end else if (exec_load) begin
            case (opcode)
                OP_LDI: write_data <= {8'h00, ir[IR_IMM_HI:IR_IMM_LO]};
                OP_ADD: write_data <= alu_result;
                OP_SUB: begin
                    write_data <= alu_result;
                    zero       <= alu_zero;
                end
                OP_OUT: result <= data_a;
                OP_NOP: ;
                default: ;
            endcase
        end
    end

    // Set on entry to WB and cleared on the next clk regardless of step,
    // so the strobe is one clk wide even when steps are slowed down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            write_enable <= 1'b0;
        else
            write_enable <= exec_load && is_write_op(opcode);
    end

    assign pc_inc = (pc + 4'd1) & PC_MASK;
    assign pc_tgt = ir[IR_TGT_HI:IR_TGT_LO] & PC_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= 4'd0;
        else if (wb_exit) begin
            case (opcode)
                OP_JMP:  pc <= pc_tgt;
                OP_BZ:   pc <= zero ? pc_tgt : pc_inc;
                default: pc <= pc_inc;
            endcase
        end
    end

    assign address = pc;

endmodule
